// File: rtl/sdram_pattern_checker_if.sv
// SDRAM read-port bundle between the pattern checker (master) and the
// memory side / read-port mux (slave).
interface sdram_pattern_checker_if #(
    parameter int ADDR_W = 25,
    parameter int W      = 16
);
    logic              read;
    logic [ADDR_W-1:0] readaddress;
    logic [W-1:0]      readdata;
    logic              readdatavalid;

    modport master (
        output read,
        output readaddress,
        input  readdata,
        input  readdatavalid
    );

    modport slave (
        input  read,
        input  readaddress,
        output readdata,
        output readdatavalid
    );
endinterface

// File: rtl/sdram_pattern_checker.sv
// Read-back checker for the KNN test-data region. Regenerates the LFSR
// test pattern (training records then input records), reads each word back
// one at a time, and reports pass/fail, a saturating error count and the
// address of the first mismatching word.
module sdram_pattern_checker #(
    parameter int M           = 6,
    parameter int N           = 10,
    parameter int W           = 16,
    parameter int TYPE_W      = 3,
    parameter int L           = 6,
    parameter int N_INPUT     = 10,
    parameter int ADDR_W      = 25,
    parameter int BASE_T_ADDR = 0,
    parameter int BASE_I_ADDR = 1 << (ADDR_W - 1),
    parameter int ADDR_STRIDE = W,
    parameter int TIMEOUT     = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    sdram_pattern_checker_if.master  rd,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     timeout,
    output logic [15:0]              error_count,
    output logic [ADDR_W-1:0]        first_err_addr
);

    localparam int WORDS   = M * N;
    localparam int N_TRAIN = 1 << L;
    localparam int N_REC   = N_TRAIN + N_INPUT;
    localparam int I_W     = $clog2(N_REC + 1);
    localparam int J_W     = $clog2(WORDS);
    localparam int T_W     = $clog2(TIMEOUT + 1);

    localparam logic [I_W-1:0]    I_TRAIN_END  = I_W'(N_TRAIN);
    localparam logic [I_W-1:0]    I_LAST_TRAIN = I_W'(N_TRAIN - 1);
    localparam logic [I_W-1:0]    I_LAST       = I_W'(N_REC - 1);
    localparam logic [J_W-1:0]    J_LAST       = J_W'(WORDS - 1);
    localparam logic [T_W-1:0]    T_LAST       = T_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] T_BASE       = ADDR_W'(BASE_T_ADDR);
    localparam logic [ADDR_W-1:0] I_BASE       = ADDR_W'(BASE_I_ADDR);
    localparam logic [ADDR_W-1:0] STRIDE       = ADDR_W'(ADDR_STRIDE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_REQ,
        S_WAIT,
        S_NEXT,
        S_FIN
    } state_t;

    state_t state_q, state_d;

    logic [6:0]        lfsr_q;
    logic [6:0]        rv_q;
    logic [W-1:0]      exp_q;
    logic [I_W-1:0]    i_q;
    logic [J_W-1:0]    j_q;
    logic [ADDR_W-1:0] addr_q;
    logic [T_W-1:0]    wait_cnt_q;
    logic              mismatch_q;

    logic [6:0]        lfsr_nxt;
    logic [6:0]        rv_new;
    logic [6:0]        rv_cur;
    logic [W-1:0]      exp_word;
    logic              last_word;

    // Same 7-bit XNOR LFSR the test-data writer uses.
    function automatic logic [6:0] lfsr_step(input logic [6:0] s);
        return {s[5:0], ~(s[6] ^ s[4] ^ s[3] ^ s[2])};
    endfunction

    // LFSR value is below 128, so one conditional subtract gives mod 100.
    function automatic logic [6:0] mod100(input logic [6:0] v);
        return (v >= 7'd100) ? (v - 7'd100) : v;
    endfunction

    // Map the random value onto the five training classes.
    function automatic logic [TYPE_W-1:0] class_type(input logic [6:0] rv);
        if (rv < 7'd20)      return TYPE_W'(1);
        else if (rv < 7'd40) return TYPE_W'(2);
        else if (rv < 7'd60) return TYPE_W'(3);
        else if (rv < 7'd80) return TYPE_W'(4);
        else                 return TYPE_W'(5);
    endfunction

    assign rd.read        = (state_q == S_REQ);
    assign rd.readaddress = addr_q;

    assign last_word = (i_q == I_LAST) && (j_q == J_LAST);

    // Expected word: a new random value at word 0 of each record, class type
    // (training) or zero (input) in word 0, the random value elsewhere.
    always_comb begin
        lfsr_nxt = lfsr_step(lfsr_q);
        rv_new   = mod100(lfsr_nxt);
        rv_cur   = (j_q == '0) ? rv_new : rv_q;
        exp_word = W'(rv_cur);
        if (j_q == '0) begin
            if (i_q < I_TRAIN_END) exp_word = W'(class_type(rv_cur));
            else                   exp_word = '0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: one word per GEN/REQ/WAIT/NEXT pass.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_GEN;
            S_GEN:  state_d = S_REQ;
            S_REQ:  state_d = S_WAIT;
            S_WAIT: begin
                if (rd.readdatavalid)         state_d = S_NEXT;
                else if (wait_cnt_q == T_LAST) state_d = S_FIN;
            end
            S_NEXT: state_d = last_word ? S_FIN : S_GEN;
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pattern generator, address accumulator, compare and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q         <= 7'd1;
            rv_q           <= '0;
            exp_q          <= '0;
            i_q            <= '0;
            j_q            <= '0;
            addr_q         <= '0;
            wait_cnt_q     <= '0;
            mismatch_q     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            error_count    <= '0;
            first_err_addr <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        error_count    <= '0;
                        first_err_addr <= '0;
                        pass           <= 1'b0;
                        timeout        <= 1'b0;
                        lfsr_q         <= 7'd1;
                        i_q            <= '0;
                        j_q            <= '0;
                        addr_q         <= T_BASE;
                        busy           <= 1'b1;
                    end
                end
                S_GEN: begin
                    if (j_q == '0) begin
                        lfsr_q <= lfsr_nxt;
                        rv_q   <= rv_new;
                    end
                    exp_q <= exp_word;
                end
                S_REQ: begin
                    wait_cnt_q <= '0;
                end
                S_WAIT: begin
                    if (rd.readdatavalid) begin
                        mismatch_q <= (rd.readdata != exp_q);
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == T_LAST) begin
                        timeout <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (mismatch_q) begin
                        if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
                        if (error_count == 16'd0)    first_err_addr <= addr_q;
                    end
                    if (j_q == J_LAST) begin
                        j_q <= '0;
                        i_q <= i_q + 1'b1;
                        // Input records live in their own region, not after training.
                        if (i_q == I_LAST_TRAIN) addr_q <= I_BASE;
                        else                     addr_q <= addr_q + STRIDE;
                    end else begin
                        j_q    <= j_q + 1'b1;
                        addr_q <= addr_q + STRIDE;
                    end
                end
                S_FIN: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (error_count == 16'd0) && !timeout;
                end
                default: ;
            endcase
        end
    end

endmodule
